// File: rtl/spi_main.sv
// SPI main controller: shifts a WordBits-wide word out MSB-first on SCK rising
// edges while capturing in_bit, with back-to-back chaining and a reload gap.
module spi_main #(
  parameter int WordBits   = 8,
  parameter int HalfPeriod = 4
) (
  input  logic                clk_i,
  input  logic                reset_i,
  output logic                sck_o,
  output logic                out_bit_o,
  input  logic                in_bit_i,
  output logic                cs_o,
  input  logic                start_i,
  input  logic [WordBits-1:0] data_word_to_send_i,
  output logic                busy_o,
  output logic                word_ready_o,
  output logic [WordBits-1:0] data_word_received_o
);

  localparam int HW = $clog2(HalfPeriod) + 1;
  localparam int BW = $clog2(WordBits) + 1;
  localparam logic [HW-1:0] HalfLoad = HW'(HalfPeriod - 1);
  localparam logic [BW-1:0] WordCnt  = BW'(WordBits);

  typedef enum logic [2:0] {IDLE, SETUP, HIGH, LOW, GAP} state_t;

  state_t              state_q, state_d;
  logic [HW-1:0]       hcnt_q, hcnt_d;
  logic [BW-1:0]       bcnt_q, bcnt_d;
  logic [WordBits-1:0] shreg_q, shreg_d;
  logic [WordBits-1:0] rx_q, rx_d;
  logic                sck_q, sck_d;
  logic                cs_q, cs_d;
  logic                out_q, out_d;
  logic                busy_q, busy_d;
  logic                wr_q, wr_d;

  logic                hc_done;
  logic                reload;
  logic [BW-1:0]       bcnt_inc;
  logic [WordBits-1:0] shifted;

  assign hc_done  = (hcnt_q == '0);
  assign bcnt_inc = bcnt_q + 1'b1;
  assign shifted  = {shreg_q[WordBits-2:0], in_bit_i};
  // Chaining is only honoured in the single cycle that carries word_ready.
  assign reload   = (state_q == LOW) && wr_q && start_i;

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q <= IDLE;
      hcnt_q  <= '0;
      bcnt_q  <= '0;
      shreg_q <= '0;
      rx_q    <= '0;
      sck_q   <= 1'b0;
      cs_q    <= 1'b1;
      out_q   <= 1'b0;
      busy_q  <= 1'b0;
      wr_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      hcnt_q  <= hcnt_d;
      bcnt_q  <= bcnt_d;
      shreg_q <= shreg_d;
      rx_q    <= rx_d;
      sck_q   <= sck_d;
      cs_q    <= cs_d;
      out_q   <= out_d;
      busy_q  <= busy_d;
      wr_q    <= wr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    hcnt_d  = hcnt_q;
    bcnt_d  = bcnt_q;
    shreg_d = shreg_q;
    rx_d    = rx_q;
    sck_d   = sck_q;
    cs_d    = cs_q;
    out_d   = out_q;
    busy_d  = busy_q;
    wr_d    = 1'b0;

    case (state_q)
      IDLE: begin
        sck_d  = 1'b0;
        cs_d   = 1'b1;
        busy_d = 1'b0;
        if (start_i) begin
          shreg_d = data_word_to_send_i;
          out_d   = data_word_to_send_i[WordBits-1];
          cs_d    = 1'b0;
          bcnt_d  = '0;
          busy_d  = 1'b1;
          hcnt_d  = HalfLoad;
          state_d = SETUP;
        end
      end
      SETUP: begin
        if (hc_done) begin
          sck_d   = 1'b1;
          hcnt_d  = HalfLoad;
          state_d = HIGH;
        end else begin
          hcnt_d = hcnt_q - 1'b1;
        end
      end
      HIGH: begin
        if (hc_done) begin
          shreg_d = shifted;
          sck_d   = 1'b0;
          bcnt_d  = bcnt_inc;
          hcnt_d  = HalfLoad;
          state_d = LOW;
          if (bcnt_inc < WordCnt) begin
            out_d = shifted[WordBits-1];
          end else begin
            rx_d = shifted;
            wr_d = 1'b1;
          end
        end else begin
          hcnt_d = hcnt_q - 1'b1;
        end
      end
      LOW: begin
        if (reload) begin
          shreg_d = data_word_to_send_i;
          out_d   = data_word_to_send_i[WordBits-1];
          bcnt_d  = '0;
        end
        if (hc_done) begin
          hcnt_d = HalfLoad;
          if ((bcnt_q == WordCnt) && !reload) begin
            cs_d    = 1'b1;
            state_d = GAP;
          end else begin
            sck_d   = 1'b1;
            state_d = HIGH;
          end
        end else begin
          hcnt_d = hcnt_q - 1'b1;
        end
      end
      GAP: begin
        if (hc_done) begin
          busy_d  = 1'b0;
          state_d = IDLE;
        end else begin
          hcnt_d = hcnt_q - 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign sck_o                = sck_q;
  assign cs_o                 = cs_q;
  assign out_bit_o            = out_q;
  assign busy_o               = busy_q;
  assign word_ready_o         = wr_q;
  assign data_word_received_o = rx_q;

endmodule

// File: tb/tb_spi_main.sv
// Directed bench for spi_main: loopback, secondary model, chaining, ignored
// start, mid-word reset, and a 12-bit / half-period-5 instance.
module tb_spi_main;

  logic        clk = 1'b0;
  logic        reset;
  logic        loop_en;
  logic [7:0]  sec_word;
  logic [7:0]  sec_tx;
  logic [7:0]  sec_rx;
  logic        sck_prev;

  logic        sck, out_bit, in_bit, cs, start, busy, word_ready;
  logic [7:0]  tx_word, rx_word;

  logic        sck2, out_bit2, cs2, start2, busy2, word_ready2;
  logic [11:0] tx_word2, rx_word2;

  int tests = 0;
  int fails = 0;
  int sck_edges = 0, wr_cnt = 0, cs_low_cnt = 0, busy_cnt = 0, sck_hi_cnt = 0;
  int sck_edges2 = 0, cs_low_cnt2 = 0;

  always #5 clk = ~clk;

  spi_main #(.WordBits(8), .HalfPeriod(4)) dut (
    .clk_i(clk), .reset_i(reset), .sck_o(sck), .out_bit_o(out_bit),
    .in_bit_i(in_bit), .cs_o(cs), .start_i(start),
    .data_word_to_send_i(tx_word), .busy_o(busy), .word_ready_o(word_ready),
    .data_word_received_o(rx_word)
  );

  spi_main #(.WordBits(12), .HalfPeriod(5)) dut2 (
    .clk_i(clk), .reset_i(reset), .sck_o(sck2), .out_bit_o(out_bit2),
    .in_bit_i(out_bit2), .cs_o(cs2), .start_i(start2),
    .data_word_to_send_i(tx_word2), .busy_o(busy2), .word_ready_o(word_ready2),
    .data_word_received_o(rx_word2)
  );

  assign in_bit = loop_en ? out_bit : sec_tx[7];

  // Secondary: loads its reply while deselected, shifts after each SCK fall,
  // captures main's bit on each SCK rise.
  always @(posedge clk) begin
    sck_prev <= sck;
    if (cs) sec_tx <= sec_word;
    else if (sck_prev && !sck) sec_tx <= {sec_tx[6:0], 1'b0};
    if (!sck_prev && sck) sec_rx <= {sec_rx[6:0], out_bit};
  end

  always @(posedge sck)  sck_edges++;
  always @(posedge sck2) sck_edges2++;

  always @(negedge clk) begin
    if (word_ready) wr_cnt++;
    if (!cs)        cs_low_cnt++;
    if (busy)       busy_cnt++;
    if (sck)        sck_hi_cnt++;
    if (!cs2)       cs_low_cnt2++;
  end

  task automatic check(input string tag, input int obs, input int exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_word(input string tag, input int budget);
    bit found = 1'b0;
    for (int i = 0; i < budget; i++) begin
      tick();
      if (word_ready) begin
        found = 1'b1;
        break;
      end
    end
    check(tag, int'(found), 1);
  endtask

  task automatic wait_idle(input string tag, input int budget);
    bit done = 1'b0;
    for (int i = 0; i < budget; i++) begin
      tick();
      if (!busy) begin
        done = 1'b1;
        break;
      end
    end
    check(tag, int'(done), 1);
  endtask

  task automatic send(input logic [7:0] w);
    tx_word = w;
    start   = 1'b1;
    tick();
    start   = 1'b0;
  endtask

  int e0, w0, c0, b0, h0;
  bit done2;

  initial begin
    reset    = 1'b1;
    loop_en  = 1'b1;
    sec_word = 8'h00;
    start    = 1'b0;
    tx_word  = 8'h00;
    start2   = 1'b0;
    tx_word2 = 12'h000;
    #1;
    check("rst_sck",   int'(sck), 0);
    check("rst_cs",    int'(cs), 1);
    check("rst_busy",  int'(busy), 0);
    check("rst_out",   int'(out_bit), 0);
    check("rst_wr",    int'(word_ready), 0);
    check("rst_rx",    int'(rx_word), 0);
    tick();
    tick();
    reset = 1'b0;
    tick();

    // Loopback 0xA5: timing of cs, busy, sck
    e0 = sck_edges; w0 = wr_cnt; c0 = cs_low_cnt; b0 = busy_cnt; h0 = sck_hi_cnt;
    send(8'hA5);
    check("a5_busy_on", int'(busy), 1);
    check("a5_cs_low",  int'(cs), 0);
    wait_idle("a5_done", 300);
    check("a5_rx",      int'(rx_word), 'hA5);
    check("a5_edges",   sck_edges - e0, 8);
    check("a5_wr",      wr_cnt - w0, 1);
    check("a5_cs_len",  cs_low_cnt - c0, 68);
    check("a5_busy_len", busy_cnt - b0, 72);
    check("a5_sck_hi",  sck_hi_cnt - h0, 32);

    // Secondary model: main 0xC3 out, secondary 0x3C back
    loop_en  = 1'b0;
    sec_word = 8'h3C;
    tick();
    tick();
    send(8'hC3);
    wait_idle("sec_done", 300);
    check("sec_rx_main", int'(rx_word), 'h3C);
    check("sec_cap",     int'(sec_rx), 'hC3);
    loop_en = 1'b1;
    tick();

    // Chained words 0x01 then 0x80 with start held
    e0 = sck_edges; w0 = wr_cnt; c0 = cs_low_cnt;
    tx_word = 8'h01;
    start   = 1'b1;
    tick();
    tx_word = 8'h80;
    wait_word("ch_wr1", 200);
    check("ch_rx1", int'(rx_word), 'h01);
    tick();
    start = 1'b0;
    check("ch_cs_held", int'(cs), 0);
    wait_word("ch_wr2", 200);
    check("ch_rx2", int'(rx_word), 'h80);
    wait_idle("ch_done", 300);
    check("ch_edges",  sck_edges - e0, 16);
    check("ch_wr",     wr_cnt - w0, 2);
    check("ch_cs_len", cs_low_cnt - c0, 132);

    // start during HIGH of bit 3 must be ignored
    e0 = sck_edges; w0 = wr_cnt; b0 = busy_cnt;
    send(8'h96);
    for (int i = 0; i < 29; i++) tick();
    check("ign_sck_high", int'(sck), 1);
    tx_word = 8'h00;
    start   = 1'b1;
    tick();
    start   = 1'b0;
    wait_idle("ign_done", 300);
    check("ign_rx",    int'(rx_word), 'h96);
    check("ign_edges", sck_edges - e0, 8);
    check("ign_wr",    wr_cnt - w0, 1);
    check("ign_busy_len", busy_cnt - b0, 72);

    // Reset in bit 4 of 0xFF aborts immediately
    w0 = wr_cnt;
    send(8'hFF);
    for (int i = 0; i < 37; i++) tick();
    check("rsm_sck_pre", int'(sck), 1);
    #2 reset = 1'b1;
    #1;
    check("rsm_sck",  int'(sck), 0);
    check("rsm_cs",   int'(cs), 1);
    check("rsm_busy", int'(busy), 0);
    check("rsm_wr",   int'(word_ready), 0);
    check("rsm_rx",   int'(rx_word), 0);
    tick();
    tick();
    reset = 1'b0;
    tick();
    check("rsm_no_wr", wr_cnt - w0, 0);
    e0 = sck_edges;
    send(8'h55);
    wait_idle("rsm_next_done", 300);
    check("rsm_next_rx",    int'(rx_word), 'h55);
    check("rsm_next_edges", sck_edges - e0, 8);
    check("rsm_next_wr",    wr_cnt - w0, 1);

    // 12-bit word, half-period 5
    e0 = sck_edges2; c0 = cs_low_cnt2;
    tx_word2 = 12'hABC;
    start2   = 1'b1;
    tick();
    start2   = 1'b0;
    done2    = 1'b0;
    for (int i = 0; i < 400; i++) begin
      tick();
      if (!busy2) begin
        done2 = 1'b1;
        break;
      end
    end
    check("w12_done",   int'(done2), 1);
    check("w12_rx",     int'(rx_word2), 'hABC);
    check("w12_edges",  sck_edges2 - e0, 12);
    check("w12_cs_len", cs_low_cnt2 - c0, 125);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/spi_main.md
SPI_MAIN -- requirements
Module: spi_main

Interface
REQ-001 Parameter WordBits, default 8, bits per SPI word; SHALL be >= 2.
REQ-002 Parameter HalfPeriod, default 4, clk cycles per SCK half-period; SHALL be >= 4 so the secondary's 3-stage SCK synchroniser resolves every edge.
REQ-003 clk  input  1  single system clock; all state SHALL update on its rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 sck  output  1  SPI clock to the secondary; idle low.
REQ-006 out_bit  output  1  main-out/secondary-in data bit.
REQ-007 in_bit  input  1  main-in/secondary-out data bit.
REQ-008 cs  output  1  channel select; high = deselected/idle, low = transfer in progress.
REQ-009 start  input  1  request to transfer data_word_to_send; sampled only when idle or at word end.
REQ-010 data_word_to_send  input  WordBits  word shifted out MSB-first.
REQ-011 busy  output  1  high from start acceptance until return to IDLE.
REQ-012 word_ready  output  1  one-cycle pulse when a full word has been received.
REQ-013 data_word_received  output  WordBits  last complete received word; stable until the next word_ready pulse.

Function
REQ-014 States SHALL be IDLE, SETUP, HIGH, LOW, GAP.
REQ-015 IDLE: sck=0, cs=1, busy=0; start=1 SHALL latch data_word_to_send into the shift register, set out_bit to its MSB, drive cs=0, clear the bit counter, set busy=1, and go to SETUP.
REQ-016 SETUP: hold sck=0 for HalfPeriod cycles, then go to HIGH with sck=1.
REQ-017 HIGH: hold sck=1 for HalfPeriod cycles; on the last HIGH cycle, sample in_bit into the shift register LSB while shifting left by one.
REQ-018 LOW: entered with sck=0 after HIGH; on entry, increment the bit counter, and if the count < WordBits, drive out_bit with the new shift-register MSB; hold for HalfPeriod cycles, then return to HIGH.
REQ-019 Word end: when the counter reaches WordBits at LOW entry, the fully shifted register SHALL be copied to data_word_received and word_ready pulsed for exactly that one cycle.
REQ-020 Chaining: if start=1 in the word-end cycle, the new data_word_to_send SHALL be latched, out_bit set to its MSB, the counter cleared, and cs kept low; the FSM continues into LOW/HIGH with no extra gap.
REQ-021 If start=0 at word end, cs SHALL rise at the end of that LOW half-period, and the FSM enters GAP.
REQ-022 GAP: cs=1, sck=0 for HalfPeriod cycles (secondary reload time), then IDLE with busy=0; start is ignored in GAP.
REQ-023 start while busy (other than at word end) SHALL be ignored; data_word_to_send is sampled only on acceptance.
REQ-024 Half-period counter width SHALL be $clog2(HalfPeriod)+1 bits; bit counter width SHALL be $clog2(WordBits)+1 bits; neither counter wraps unobserved.
REQ-025 Exactly WordBits rising SCK edges SHALL occur per word; sck SHALL never glitch (registered output).

Reset
REQ-026 While reset=1, regardless of clk: state=IDLE, sck=0, cs=1, out_bit=0, busy=0, word_ready=0, data_word_received=0, all counters 0.
REQ-027 Reset asserted mid-word SHALL abort the transfer immediately without a word_ready pulse; the first transfer after deassertion SHALL start cleanly from IDLE.

Verification
REQ-028 WordBits=8, HalfPeriod=4, send 0xA5, loopback out_bit->in_bit -> 8 sck pulses of 8 clk period, word_ready one pulse, data_word_received=0xA5, cs low for 4+64 cycles, then GAP 4 cycles, busy=0.
REQ-029 Secondary model returning 0x3C while main sends 0xC3 -> received 0x3C; model captures 0xC3.
REQ-030 start held high with 0x01 then 0x80 -> two word_ready pulses, cs stays low between words, received 0x01 then 0x80 (loopback), 16 sck rising edges total.
REQ-031 start pulsed during the HIGH phase of bit 3 -> ignored; exactly one word transferred.
REQ-032 reset asserted after 4 bits of 0xFF -> sck=0, cs=1, busy=0 at once, no word_ready; next transfer of 0x55 completes correctly.
REQ-033 WordBits=12, HalfPeriod=5, send 0xABC loopback -> 12 sck edges, received 0xABC.
